// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
// Contents: default requester count and payload width, the FSM state encoding,
// and a helper that sizes requester index fields.
package uart_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 9;

    // FSM state encoding, kept as plain constants so older blocks can share it
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Width of a requester index. It is never narrower than one bit,
    // so a single-requester build still has a legal index field.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester and transmitter signals for uart_tx_arbiter.
//   req / req_data       : level requests and payloads, from the requesters
//   gnt                  : one-cycle accept pulse, back to the requesters
//   tx_ready             : transmitter idle indication
//   tx_send / tx_data    : frame start pulse and payload, to the transmitter
//   busy / frames_sent   : status
// Modport master is the environment (requesters plus transmitter).
// Modport slave is the arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      tx_ready;
    logic                      tx_send;
    logic [DATA_W-1:0]         tx_data;
    logic                      busy;
    logic [15:0]               frames_sent;

    modport master (
        output req, req_data, tx_ready,
        input  gnt, tx_send, tx_data, busy, frames_sent
    );

    modport slave (
        input  req, req_data, tx_ready,
        output gnt, tx_send, tx_data, busy, frames_sent
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority rotation.
// The search starts at index (last+1) mod NUM_REQ and wraps upward.
//   req       : pending requests
//   last      : index of the previous winner
//   grant     : one-hot winner, all zero when nothing is pending
//   grant_idx : binary index of the winner
//   valid     : at least one request is pending
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               valid
);

    logic             found_s;
    logic             hit_s;
    int               cand_v;
    logic [IDX_W-1:0] cand_idx_s;

    // Walk the requesters in rotated order; the first pending one wins
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        found_s    = 1'b0;
        hit_s      = 1'b0;
        cand_v     = 0;
        cand_idx_s = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_v             = (int'(last) + k) % NUM_REQ;
            cand_idx_s         = IDX_W'(cand_v);
            hit_s              = req[cand_idx_s] & ~found_s;
            grant[cand_idx_s]  = hit_s;
            grant_idx          = hit_s ? cand_idx_s : grant_idx;
            found_s            = found_s | hit_s;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds frames from NUM_REQ requesters into one UART
// transmitter.
//   clock, reset_n : system clock and asynchronous active-low reset
//   bus (slave)    : requester and transmitter handshake (see uart_tx_arbiter_if)
// The FSM runs IDLE -> SEND -> WAIT -> IDLE. The grant decision is combinational
// in IDLE, and the winner's payload is captured on that same edge. tx_send
// pulses during SEND. WAIT ends once the transmitter has been seen low and then
// reports ready again, which counts one completed frame.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic           clock,
    input  logic           reset_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [1:0]         state_r;
    logic [1:0]         next_s;
    logic [IDX_W-1:0]   last_r;
    logic               seen_low_r;
    logic [DATA_W-1:0]  tx_data_r;
    logic               tx_send_r;
    logic               busy_r;
    logic [15:0]        frames_r;

    logic [NUM_REQ-1:0] win_grant_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               win_valid_s;
    logic               arb_go_s;
    logic               frame_done_s;
    logic [DATA_W-1:0]  data_arr_s [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (bus.req),
        .last      (last_r),
        .grant     (win_grant_s),
        .grant_idx (win_idx_s),
        .valid     (win_valid_s)
    );

    // Split the flat payload bus into one entry per requester
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr_s[i] = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // Next-state decode; arbitration happens only when leaving IDLE
    always_comb begin
        next_s       = state_r;
        arb_go_s     = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.tx_ready && win_valid_s) begin
                    next_s   = ST_SEND;
                    arb_go_s = 1'b1;
                end else begin
                    next_s   = ST_IDLE;
                end
            end
            ST_SEND: begin
                next_s = ST_WAIT;
            end
            ST_WAIT: begin
                // Ready alone is not enough: the transmitter must first drop ready
                if (bus.tx_ready && seen_low_r) begin
                    next_s       = ST_IDLE;
                    frame_done_s = 1'b1;
                end else begin
                    next_s       = ST_WAIT;
                end
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // State, status and start-pulse registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            tx_send_r <= 1'b0;
        end else begin
            state_r   <= next_s;
            busy_r    <= (next_s != ST_IDLE);
            tx_send_r <= arb_go_s;
        end
    end

    // Capture the winner's payload and remember the winner for the next rotation
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_data_r <= '0;
            last_r    <= IDX_W'(NUM_REQ - 1);
        end else if (arb_go_s) begin
            tx_data_r <= data_arr_s[win_idx_s];
            last_r    <= win_idx_s;
        end
    end

    // Record that the transmitter went busy during WAIT; clear it when the frame completes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seen_low_r <= 1'b0;
        end else if (frame_done_s) begin
            seen_low_r <= 1'b0;
        end else if ((state_r == ST_WAIT) && !bus.tx_ready) begin
            seen_low_r <= 1'b1;
        end
    end

    // Completed-frame counter; it wraps naturally at 16 bits
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frames_r <= 16'd0;
        end else if (frame_done_s) begin
            frames_r <= frames_r + 16'd1;
        end
    end

    // Grant is decided in the accepting cycle; it is held off while reset is asserted
    assign bus.gnt         = (arb_go_s && reset_n) ? win_grant_s : {NUM_REQ{1'b0}};
    assign bus.tx_send     = tx_send_r;
    assign bus.tx_data     = tx_data_r;
    assign bus.busy        = busy_r;
    assign bus.frames_sent = frames_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter.
// Tests push the grants and payloads they expect into a queue. A monitor pops
// that queue whenever gnt pulses, then checks the following tx_send and tx_data.
// The transmitter model drops tx_ready for a configurable number of cycles
// after each tx_send.
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [8:0] d;
    } exp_t;

    logic clock;
    logic reset_n;
    logic tx_ready_m;
    logic tx_block;
    int   tx_low_cycles;
    int   n_checks;
    int   n_fail;
    int   gnt_count;
    logic gnt_prev;
    exp_t exp_q [$];
    logic [8:0] txq [$];

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(9)) bus ();

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(9)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.tx_ready = tx_ready_m & ~tx_block;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Transmitter model: it goes not-ready right after each start pulse
    initial begin
        tx_ready_m = 1'b1;
        forever begin
            @(negedge clock);
            if (bus.tx_send === 1'b1) begin
                @(posedge clock); #1;
                tx_ready_m = 1'b0;
                repeat (tx_low_cycles) @(posedge clock);
                #1;
                tx_ready_m = 1'b1;
            end
        end
    end

    // Monitor: scoreboard for gnt, tx_send and tx_data
    initial begin
        exp_t e;
        gnt_prev  = 1'b0;
        gnt_count = 0;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1) begin
                if (bus.tx_send === 1'b1 || gnt_prev) begin
                    check_eq("tx_send_after_gnt", {31'd0, bus.tx_send}, {31'd0, gnt_prev});
                end
                if (bus.tx_send === 1'b1) begin
                    if (txq.size() == 0) begin
                        check_eq("tx_send_unexpected", {31'd0, bus.tx_send}, 32'd0);
                    end else begin
                        check_eq("tx_data", {23'd0, bus.tx_data}, {23'd0, txq.pop_front()});
                    end
                end
                gnt_prev = (bus.gnt != 4'd0);
                if (bus.gnt != 4'd0) begin
                    gnt_count++;
                    if (exp_q.size() == 0) begin
                        check_eq("gnt_unexpected", {28'd0, bus.gnt}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("gnt_order", {28'd0, bus.gnt}, {28'd0, e.g});
                        txq.push_back(e.d);
                    end
                end
            end else begin
                check_eq("gnt_in_reset", {28'd0, bus.gnt}, 32'd0);
                gnt_prev = 1'b0;
                txq.delete();
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        bus.req = 4'd0;
        repeat (2) @(negedge clock);
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_gnt(input int target, input string tag);
        int k;
        k = 0;
        while (gnt_count < target && k < 400) begin
            @(negedge clock); #1;
            k++;
        end
        if (gnt_count < target) begin
            check_eq({tag, "_gnt_timeout"}, gnt_count, target);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        @(negedge clock);
        while (bus.busy !== 1'b0 && k < 400) begin
            @(negedge clock);
            k++;
        end
        if (bus.busy !== 1'b0) begin
            check_eq({tag, "_idle_timeout"}, {31'd0, bus.busy}, 32'd0);
        end
    endtask

    task automatic set_data(input int idx, input logic [8:0] d);
        bus.req_data[idx*9 +: 9] = d;
    endtask

    initial begin
        int base;
        n_checks      = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        tx_block      = 1'b0;
        tx_low_cycles = 10;
        bus.req       = 4'd0;
        bus.req_data  = '0;

        // Reset state
        do_reset();
        @(negedge clock);
        check_eq("rst_gnt",    {28'd0, bus.gnt}, 32'd0);
        check_eq("rst_tx_send", {31'd0, bus.tx_send}, 32'd0);
        check_eq("rst_tx_data", {23'd0, bus.tx_data}, 32'd0);
        check_eq("rst_busy",   {31'd0, bus.busy}, 32'd0);
        check_eq("rst_frames", {16'd0, bus.frames_sent}, 32'd0);

        // Single request from requester 2
        exp_q.push_back('{g: 4'b0100, d: 9'h1A5});
        @(posedge clock); #1;
        set_data(2, 9'h1A5);
        bus.req = 4'b0100;
        @(negedge clock);
        check_eq("single_gnt_same_cycle", {28'd0, bus.gnt}, 32'h4);
        @(posedge clock); #1;
        bus.req = 4'd0;
        wait_idle("single");
        check_eq("single_frames", {16'd0, bus.frames_sent}, 32'd1);
        check_eq("single_busy", {31'd0, bus.busy}, 32'd0);

        // All requesting: the grants rotate 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_data(i, 9'(9'h100 + i));
        end
        exp_q.push_back('{g: 4'b0001, d: 9'h100});
        exp_q.push_back('{g: 4'b0010, d: 9'h101});
        exp_q.push_back('{g: 4'b0100, d: 9'h102});
        exp_q.push_back('{g: 4'b1000, d: 9'h103});
        exp_q.push_back('{g: 4'b0001, d: 9'h100});
        base = gnt_count;
        @(posedge clock); #1;
        bus.req = 4'b1111;
        wait_gnt(base + 5, "all");
        @(posedge clock); #1;
        bus.req = 4'd0;
        wait_idle("all");
        check_eq("all_frames", {16'd0, bus.frames_sent}, 32'd5);

        // Blocked transmitter: no grant until ready, then a grant in the same cycle
        do_reset();
        tx_block = 1'b1;
        set_data(1, 9'h0F3);
        @(posedge clock); #1;
        bus.req = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check_eq("blocked_gnt",  {28'd0, bus.gnt}, 32'd0);
            check_eq("blocked_busy", {31'd0, bus.busy}, 32'd0);
        end
        exp_q.push_back('{g: 4'b0010, d: 9'h0F3});
        @(posedge clock); #1;
        tx_block = 1'b0;
        @(negedge clock);
        check_eq("unblocked_gnt", {28'd0, bus.gnt}, 32'h2);
        @(posedge clock); #1;
        bus.req = 4'd0;
        wait_idle("blocked");
        check_eq("blocked_frames", {16'd0, bus.frames_sent}, 32'd1);

        // Reset mid-frame: the frame is dropped without a count, and requester 0 wins after release
        exp_q.push_back('{g: 4'b0100, d: 9'h0AA});
        base = gnt_count;
        set_data(2, 9'h0AA);
        @(posedge clock); #1;
        bus.req = 4'b0100;
        wait_gnt(base + 1, "midrst");
        @(posedge clock); #1;
        bus.req = 4'd0;
        repeat (4) @(negedge clock);
        check_eq("midrst_in_wait", {31'd0, bus.busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_tx_send", {31'd0, bus.tx_send}, 32'd0);
        check_eq("midrst_busy",    {31'd0, bus.busy}, 32'd0);
        check_eq("midrst_frames",  {16'd0, bus.frames_sent}, 32'd0);
        set_data(0, 9'h155);
        bus.req = 4'b0001;
        exp_q.push_back('{g: 4'b0001, d: 9'h155});
        base = gnt_count;
        @(posedge clock); #1;
        reset_n = 1'b1;
        wait_gnt(base + 1, "postrst");
        @(posedge clock); #1;
        bus.req = 4'd0;
        wait_idle("postrst");
        check_eq("postrst_frames", {16'd0, bus.frames_sent}, 32'd1);

        // Counter wrap from 0xFFFF
        do_reset();
        @(negedge clock);
        force dut.frames_r = 16'hFFFF;
        @(posedge clock); #1;
        release dut.frames_r;
        @(negedge clock);
        check_eq("wrap_preload", {16'd0, bus.frames_sent}, 32'hFFFF);
        exp_q.push_back('{g: 4'b1000, d: 9'h1FF});
        base = gnt_count;
        set_data(3, 9'h1FF);
        @(posedge clock); #1;
        bus.req = 4'b1000;
        wait_gnt(base + 1, "wrap");
        @(posedge clock); #1;
        bus.req = 4'd0;
        wait_idle("wrap");
        check_eq("wrap_frames", {16'd0, bus.frames_sent}, 32'd0);

        // Withdrawal: requester 3 drops while busy, so requester 0 is served next
        do_reset();
        set_data(0, 9'h011);
        set_data(2, 9'h022);
        set_data(3, 9'h033);
        exp_q.push_back('{g: 4'b0100, d: 9'h022});
        exp_q.push_back('{g: 4'b0001, d: 9'h011});
        base = gnt_count;
        @(posedge clock); #1;
        bus.req = 4'b0100;
        wait_gnt(base + 1, "wd_first");
        @(posedge clock); #1;
        bus.req = 4'b1001;
        repeat (3) @(posedge clock);
        #1;
        check_eq("wd_busy_at_drop", {31'd0, bus.busy}, 32'd1);
        bus.req = 4'b0001;
        wait_gnt(base + 2, "wd_second");
        @(posedge clock); #1;
        bus.req = 4'd0;
        wait_idle("wd");
        repeat (20) @(negedge clock);
        check_eq("wd_frames", {16'd0, bus.frames_sent}, 32'd2);
        check_eq("exp_queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit: a hung run fails loudly instead of spinning forever
    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1);
    end

endmodule
